bpf_branch_stage: RTL and testbench
===================================

# bpf_branch_stage

Parametrised successor to the stage-2 control register of the pipelined BPF controller. Holds one instruction's control bundle and resolves conditional jumps from the ALU flags into a registered `PC_sel`. Uses a valid/ready handshake, so stage 3 may back-pressure and the hazard unit may squash. Optionally keeps branch statistics. Sits between the stage-1 decoder and the stage-3 register/PC update logic.

## Interface
Parameters:
- `CTRL_W`, 16: width of the stage-2 control bundle (ALU_sel, mem rd, transfer size, regfile controls, …).
- `S3_W`, 8: width of the stage-3 bundle (A_sel, A_en, X_sel, X_en).
- `CNT_W`, 32: width of the statistics counters.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: stage-1 presents an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `is_jmp` in 1: the instruction is a jump (replaces the old use of `PC_en_in`).
- `jmp_type` in 3: JA=0, JEQ=1, JGT=2, JGE=3, JSET=4; 5–7 are illegal.
- `eq`, `gt`, `ge`, `set` in 1 each: ALU flags, valid in the cycle the instruction is presented.
- `ctrl_in` in CTRL_W: stage-2 control bundle.
- `s3_in` in S3_W: stage-3 control bundle.
- `flush` in 1: squash the held entry and any incoming entry.
- `out_valid` out 1: registered entry valid.
- `out_ready` in 1: stage 3 consumes the entry.
- `PC_sel` out 3: PLUS_JT=1, PLUS_JF=2, PLUS_IMM=3; 0 when no jump.
- `PC_en` out 1: the registered entry is a jump.
- `branch_taken` out 1: registered jump is JA or a true conditional.
- `illegal_jmp` out 1: registered jump had `jmp_type` 5–7.
- `ctrl_out` out CTRL_W: registered bundle.
- `s3_out` out S3_W: registered bundle.
- `stat_clr` in 1: synchronous clear of the counters.
- `jmp_cnt` out CNT_W: count of jumps accepted.
- `taken_cnt` out CNT_W: count of taken jumps accepted.

## Operation
- `in_ready = !out_valid || out_ready`, combinational.
- **Load** (accept = `in_valid && in_ready && !flush`): all outputs are registered from the inputs and `out_valid` goes to 1.
- **Bubble** (`in_ready && (!in_valid || flush)`): `out_valid`, `PC_sel`, `PC_en`, `branch_taken`, `illegal_jmp`, `ctrl_out` and `s3_out` all load 0. Control outputs are always 0 when invalid, which preserves the OR-combine rule across stages.
- **Stall** (`out_valid && !out_ready`): all outputs hold. If `flush` is asserted during a stall, the entry is zeroed next cycle (flush beats hold).
- **Jump resolution**, applied at load when `is_jmp=1`:
  - JA gives PLUS_IMM, taken.
  - JEQ&eq, JGT&gt, JGE&ge or JSET&set gives PLUS_JT, taken.
  - Any other legal type gives PLUS_JF, not taken.
  - Types 5–7 give PLUS_JF, `illegal_jmp=1`, not taken.
- **Non-jump** (`is_jmp=0`): `PC_sel=0`, `PC_en=0`. Flags are ignored.
- **Two states**: EMPTY (`out_valid=0`) and FULL. EMPTY goes to FULL on load. FULL goes to EMPTY on `out_ready` with no load, or on `flush`. FULL stays FULL on stall or on simultaneous consume and load.

## Timing
- Latency is 1 cycle from accept to `out_valid`. Throughput is 1 instruction per cycle when `out_ready=1`.
- Flags are sampled only on the accepting edge. Flag changes while stalled have no effect.
- Reset drives every registered output to 0, including the counters. `in_ready` is 1 during and after reset.
- Reset asserted mid-stall discards the entry immediately (asynchronous).
- `flush` and `in_valid` in the same cycle: the input is dropped and nothing is loaded.

## Configuration
- `BPF_BRANCH_STATS_EN` defined:
  - On each accept with `is_jmp=1`, `jmp_cnt` increments.
  - On each accept with `is_jmp=1` that resolves taken, `taken_cnt` increments.
  - Both counters saturate at all-ones.
  - `stat_clr` zeroes both counters and takes precedence over a same-cycle increment.
- Not defined: no counter logic. `jmp_cnt` and `taken_cnt` are tied to 0 and `stat_clr` is ignored. Ports are unchanged.

## Test plan
- Reset, then JEQ with eq=1 and out_ready=1 → next cycle `out_valid=1`, `PC_sel=1`, `PC_en=1`, `branch_taken=1`. The following cycle with in_valid=0 → all outputs 0.
- Back-to-back JA, JGT with gt=0, JSET with set=1, then a non-jump with ctrl_in=16'hA5A5 → `PC_sel` reads 3, 2, 1, 0 on consecutive cycles; `ctrl_out`=16'hA5A5 on the last.
- Load JGE with ge=1, hold out_ready=0 for 3 cycles while toggling ge and in_valid → outputs frozen, `in_ready=0`. Release → the next instruction loads on the same edge the entry is consumed.
- Stalled FULL entry plus `flush`=1 with in_valid=1 → next cycle `out_valid=0`, `PC_sel=0`, new input dropped. `jmp_cnt` is not incremented for the dropped input.
- `jmp_type`=6 with `is_jmp`=1 → `PC_sel=2`, `illegal_jmp=1`, `branch_taken=0`.
- With `BPF_BRANCH_STATS_EN` defined:
  - CNT_W=4, 20 taken jumps → `jmp_cnt` = `taken_cnt` = 4'hF (saturated).
  - `stat_clr` in the same cycle as an accepted jump → both counters 0.

Source files
------------

// File: rtl/bpf_branch_stage.sv
// BPF stage-2 control register with registered jump resolution and valid/ready handshake.
// Optional saturating branch counters enabled by defining BPF_BRANCH_STATS_EN.
module bpf_branch_stage #(
   parameter int CTRL_W = 16,
   parameter int S3_W   = 8,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              is_jmp,
   input  logic [2:0]        jmp_type,
   input  logic              eq,
   input  logic              gt,
   input  logic              ge,
   input  logic              set,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [S3_W-1:0]   s3_in,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        PC_sel,
   output logic              PC_en,
   output logic              branch_taken,
   output logic              illegal_jmp,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic [S3_W-1:0]   s3_out,
   input  logic              stat_clr,
   output logic [CNT_W-1:0]  jmp_cnt,
   output logic [CNT_W-1:0]  taken_cnt
);

   typedef enum logic {EMPTY, FULL} state_e;

   localparam logic [2:0] PLUS_JT  = 3'd1;
   localparam logic [2:0] PLUS_JF  = 3'd2;
   localparam logic [2:0] PLUS_IMM = 3'd3;

   state_e            state_q, state_d;
   logic [2:0]        pc_sel_q, pc_sel_d;
   logic              pc_en_q, pc_en_d;
   logic              taken_q, taken_d;
   logic              illegal_q, illegal_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [S3_W-1:0]   s3_q, s3_d;

   logic       accept;
   logic [2:0] br_sel;
   logic       br_taken;
   logic       br_illegal;

   assign out_valid = (state_q == FULL);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready && !flush;

   always_comb begin
      br_sel     = 3'd0;
      br_taken   = 1'b0;
      br_illegal = 1'b0;
      if (is_jmp) begin
         case (jmp_type)
            3'd0: begin
               br_sel   = PLUS_IMM;
               br_taken = 1'b1;
            end
            3'd1: br_taken = eq;
            3'd2: br_taken = gt;
            3'd3: br_taken = ge;
            3'd4: br_taken = set;
            default: br_illegal = 1'b1;
         endcase
         if (jmp_type != 3'd0)
            br_sel = br_taken ? PLUS_JT : PLUS_JF;
      end
   end

   // Flush zeroes the entry even while stalled; otherwise a stall holds.
   always_comb begin
      state_d   = state_q;
      pc_sel_d  = pc_sel_q;
      pc_en_d   = pc_en_q;
      taken_d   = taken_q;
      illegal_d = illegal_q;
      ctrl_d    = ctrl_q;
      s3_d      = s3_q;
      if (accept) begin
         state_d   = FULL;
         pc_sel_d  = br_sel;
         pc_en_d   = is_jmp;
         taken_d   = br_taken;
         illegal_d = br_illegal;
         ctrl_d    = ctrl_in;
         s3_d      = s3_in;
      end else if (in_ready || flush) begin
         state_d   = EMPTY;
         pc_sel_d  = 3'd0;
         pc_en_d   = 1'b0;
         taken_d   = 1'b0;
         illegal_d = 1'b0;
         ctrl_d    = '0;
         s3_d      = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= EMPTY;
         pc_sel_q  <= 3'd0;
         pc_en_q   <= 1'b0;
         taken_q   <= 1'b0;
         illegal_q <= 1'b0;
         ctrl_q    <= '0;
         s3_q      <= '0;
      end else begin
         state_q   <= state_d;
         pc_sel_q  <= pc_sel_d;
         pc_en_q   <= pc_en_d;
         taken_q   <= taken_d;
         illegal_q <= illegal_d;
         ctrl_q    <= ctrl_d;
         s3_q      <= s3_d;
      end
   end

   assign PC_sel       = pc_sel_q;
   assign PC_en        = pc_en_q;
   assign branch_taken = taken_q;
   assign illegal_jmp  = illegal_q;
   assign ctrl_out     = ctrl_q;
   assign s3_out       = s3_q;

`ifdef BPF_BRANCH_STATS_EN
   logic [CNT_W-1:0] jmp_cnt_q, jmp_cnt_d;
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
   logic             inc_jmp, inc_taken;

   assign inc_jmp   = accept && is_jmp;
   assign inc_taken = inc_jmp && br_taken;

   always_comb begin
      jmp_cnt_d   = jmp_cnt_q;
      taken_cnt_d = taken_cnt_q;
      if (stat_clr) begin
         jmp_cnt_d   = '0;
         taken_cnt_d = '0;
      end else begin
         if (inc_jmp && !(&jmp_cnt_q))
            jmp_cnt_d = jmp_cnt_q + CNT_W'(1);
         if (inc_taken && !(&taken_cnt_q))
            taken_cnt_d = taken_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         jmp_cnt_q   <= '0;
         taken_cnt_q <= '0;
      end else begin
         jmp_cnt_q   <= jmp_cnt_d;
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign jmp_cnt   = jmp_cnt_q;
   assign taken_cnt = taken_cnt_q;
`else
   logic unused_stat_clr;
   assign unused_stat_clr = stat_clr;
   assign jmp_cnt         = '0;
   assign taken_cnt       = '0;
`endif

endmodule

// File: tb/tb_bpf_branch_stage.sv
// Directed bench for bpf_branch_stage; counters run 4 bits wide to reach saturation.
module tb_bpf_branch_stage;

   localparam int CTRL_W = 16;
   localparam int S3_W   = 8;
   localparam int CNT_W  = 4;
`ifdef BPF_BRANCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid, in_ready, is_jmp;
   logic [2:0]        jmp_type;
   logic              eq, gt, ge, set;
   logic [CTRL_W-1:0] ctrl_in, ctrl_out;
   logic [S3_W-1:0]   s3_in, s3_out;
   logic              flush, out_valid, out_ready;
   logic [2:0]        PC_sel;
   logic              PC_en, branch_taken, illegal_jmp, stat_clr;
   logic [CNT_W-1:0]  jmp_cnt, taken_cnt;

   int n_checks = 0;
   int n_errors = 0;

   bpf_branch_stage #(.CTRL_W(CTRL_W), .S3_W(S3_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .is_jmp(is_jmp), .jmp_type(jmp_type),
      .eq(eq), .gt(gt), .ge(ge), .set(set),
      .ctrl_in(ctrl_in), .s3_in(s3_in), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .PC_sel(PC_sel), .PC_en(PC_en),
      .branch_taken(branch_taken), .illegal_jmp(illegal_jmp),
      .ctrl_out(ctrl_out), .s3_out(s3_out),
      .stat_clr(stat_clr), .jmp_cnt(jmp_cnt), .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic j, input logic [2:0] t,
                        input logic [CTRL_W-1:0] c);
      in_valid = v;
      is_jmp   = j;
      jmp_type = t;
      ctrl_in  = c;
      s3_in    = c[7:0];
   endtask

   function automatic logic [31:0] cnt(input int v);
      return STATS ? 32'(v) : 32'd0;
   endfunction

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 3'd0, 16'h0);
      {eq, gt, ge, set} = 4'b0;
      flush = 1'b0; out_ready = 1'b1; stat_clr = 1'b0;
      #3;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_pcsel", 32'(PC_sel), 32'd0);
      chk("rst_jcnt", 32'(jmp_cnt), 32'd0);
      #5 rst = 1'b0;
      #1;

      // JEQ taken, then bubble
      drive(1'b1, 1'b1, 3'd1, 16'h0101);
      eq = 1'b1;
      step();
      chk("jeq_valid", 32'(out_valid), 32'd1);
      chk("jeq_pcsel", 32'(PC_sel), 32'd1);
      chk("jeq_pcen", 32'(PC_en), 32'd1);
      chk("jeq_taken", 32'(branch_taken), 32'd1);
      drive(1'b0, 1'b1, 3'd0, 16'hFFFF);
      step();
      chk("bub_valid", 32'(out_valid), 32'd0);
      chk("bub_pcsel", 32'(PC_sel), 32'd0);
      chk("bub_pcen", 32'(PC_en), 32'd0);
      chk("bub_taken", 32'(branch_taken), 32'd0);
      chk("bub_ctrl", 32'(ctrl_out), 32'd0);
      chk("bub_s3", 32'(s3_out), 32'd0);

      // back-to-back JA, JGT not taken, JSET taken, non-jump
      {eq, gt, ge, set} = 4'b0;
      drive(1'b1, 1'b1, 3'd0, 16'h0001);
      step();
      chk("ja_pcsel", 32'(PC_sel), 32'd3);
      drive(1'b1, 1'b1, 3'd2, 16'h0002);
      step();
      chk("jgt_pcsel", 32'(PC_sel), 32'd2);
      chk("jgt_taken", 32'(branch_taken), 32'd0);
      drive(1'b1, 1'b1, 3'd4, 16'h0003);
      set = 1'b1;
      step();
      chk("jset_pcsel", 32'(PC_sel), 32'd1);
      drive(1'b1, 1'b0, 3'd0, 16'hA5A5);
      step();
      chk("nj_pcsel", 32'(PC_sel), 32'd0);
      chk("nj_pcen", 32'(PC_en), 32'd0);
      chk("nj_ctrl", 32'(ctrl_out), 32'h0000A5A5);
      chk("nj_s3", 32'(s3_out), 32'h000000A5);
      chk("cnt4_j", 32'(jmp_cnt), cnt(4));
      chk("cnt4_t", 32'(taken_cnt), cnt(3));

      // JGE taken, then stall for 3 cycles
      {eq, gt, ge, set} = 4'b0010;
      drive(1'b1, 1'b1, 3'd3, 16'h1111);
      step();
      chk("jge_pcsel", 32'(PC_sel), 32'd1);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ge = ~ge;
         drive(i[0], 1'b1, 3'd2, 16'h3333);
         #1;
         chk("stl_ready", 32'(in_ready), 32'd0);
         step();
         chk("stl_valid", 32'(out_valid), 32'd1);
         chk("stl_pcsel", 32'(PC_sel), 32'd1);
         chk("stl_ctrl", 32'(ctrl_out), 32'h00001111);
      end
      out_ready = 1'b1;
      drive(1'b1, 1'b1, 3'd0, 16'h2222);
      #1;
      chk("rel_ready", 32'(in_ready), 32'd1);
      step();
      chk("rel_pcsel", 32'(PC_sel), 32'd3);
      chk("rel_ctrl", 32'(ctrl_out), 32'h00002222);

      // flush during stall with an incoming jump
      out_ready = 1'b0;
      flush = 1'b1;
      drive(1'b1, 1'b1, 3'd0, 16'h4444);
      step();
      flush = 1'b0;
      chk("fl_valid", 32'(out_valid), 32'd0);
      chk("fl_pcsel", 32'(PC_sel), 32'd0);
      chk("fl_ctrl", 32'(ctrl_out), 32'd0);
      chk("fl_jcnt", 32'(jmp_cnt), cnt(6));
      chk("fl_tcnt", 32'(taken_cnt), cnt(5));

      // illegal type
      out_ready = 1'b1;
      drive(1'b1, 1'b1, 3'd6, 16'h5555);
      step();
      chk("ill_pcsel", 32'(PC_sel), 32'd2);
      chk("ill_flag", 32'(illegal_jmp), 32'd1);
      chk("ill_taken", 32'(branch_taken), 32'd0);
      chk("ill_jcnt", 32'(jmp_cnt), cnt(7));

      // clear wins over a same-cycle accepted jump
      stat_clr = 1'b1;
      drive(1'b1, 1'b1, 3'd0, 16'h6666);
      step();
      stat_clr = 1'b0;
      chk("clr_jcnt", 32'(jmp_cnt), 32'd0);
      chk("clr_tcnt", 32'(taken_cnt), 32'd0);
      chk("clr_ill", 32'(illegal_jmp), 32'd0);

      // saturation after 20 taken jumps
      for (int i = 0; i < 20; i++) step();
      chk("sat_jcnt", 32'(jmp_cnt), cnt(15));
      chk("sat_tcnt", 32'(taken_cnt), cnt(15));

      // asynchronous reset mid-stall
      out_ready = 1'b0;
      drive(1'b0, 1'b0, 3'd0, 16'h0);
      step();
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_pcsel", 32'(PC_sel), 32'd0);
      chk("arst_ready", 32'(in_ready), 32'd1);
      chk("arst_jcnt", 32'(jmp_cnt), 32'd0);
      rst = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
